// File: rtl/spi_slave_if.sv
// SPI pins plus the parallel RAM-side handshake of the SPI slave front end.
// The slave modport is the serial engine's view; master is the driving side (SPI master + RAM).
interface spi_slave_if #(
    parameter int ADDR_SIZE = 8
);
    logic                   SS_n;
    logic                   MOSI;
    logic                   MISO;
    logic [ADDR_SIZE+1:0]   rx_data;
    logic                   rx_valid;
    logic [ADDR_SIZE-1:0]   tx_data;
    logic                   tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave serial engine: collects ADDR_SIZE+2 bit frames from MOSI into rx_data and,
// for read-data frames, returns the RAM's tx_data MSB first on MISO.
module spi_slave #(
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    localparam int N  = ADDR_SIZE + 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_FRAME = CW'(N - 1);
    localparam logic [CW-1:0] CNT_SEND  = CW'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    // Progress within a frame once the command bit has been taken.
    typedef enum logic [1:0] {PH_SHIFT, PH_WAIT, PH_SEND, PH_DONE} phase_t;

    state_t                 state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N-2:0]           shift_q, shift_d;
    logic [ADDR_SIZE-1:0]   tx_buf_q, tx_buf_d;
    logic                   rd_addr_flag_q, rd_addr_flag_d;
    logic                   miso_q, miso_d;
    logic [N-1:0]           rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            phase_q        <= PH_SHIFT;
            cnt_q          <= '0;
            shift_q        <= '0;
            tx_buf_q       <= '0;
            rd_addr_flag_q <= 1'b0;
            miso_q         <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            tx_buf_q       <= tx_buf_d;
            rd_addr_flag_q <= rd_addr_flag_d;
            miso_q         <= miso_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        tx_buf_d       = tx_buf_q;
        rd_addr_flag_d = rd_addr_flag_q;
        miso_d         = miso_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;

        // Deselect beats everything, including a final bit arriving on the same edge.
        if (bus.SS_n) begin
            state_d = IDLE;
            phase_d = PH_SHIFT;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                    phase_d = PH_SHIFT;
                    cnt_d   = CNT_FRAME;
                end
                CHK_CMD: begin
                    shift_d = {{(N-2){1'b0}}, bus.MOSI};
                    cnt_d   = cnt_q - CW'(1);
                    if (!bus.MOSI)          state_d = WRITE;
                    else if (rd_addr_flag_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    case (phase_q)
                        PH_SHIFT: begin
                            if (cnt_q == '0) begin
                                rx_data_d  = {shift_q, bus.MOSI};
                                rx_valid_d = 1'b1;
                                if (state_q == READ_ADD) rd_addr_flag_d = 1'b1;
                                phase_d = (state_q == READ_DATA) ? PH_WAIT : PH_DONE;
                            end else begin
                                shift_d = {shift_q[N-3:0], bus.MOSI};
                                cnt_d   = cnt_q - CW'(1);
                            end
                        end
                        PH_WAIT: begin
                            if (state_q == READ_DATA && bus.tx_valid) begin
                                miso_d   = bus.tx_data[ADDR_SIZE-1];
                                tx_buf_d = bus.tx_data << 1;
                                cnt_d    = CNT_SEND;
                                phase_d  = PH_SEND;
                            end
                        end
                        PH_SEND: begin
                            // cnt_q counts bits still to present after the current one.
                            if (cnt_q != '0) begin
                                miso_d   = tx_buf_q[ADDR_SIZE-1];
                                tx_buf_d = tx_buf_q << 1;
                                cnt_d    = cnt_q - CW'(1);
                            end else begin
                                miso_d         = 1'b0;
                                rd_addr_flag_d = 1'b0;
                                phase_d        = PH_DONE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: expected frames and MISO bits are queued as stimulus is
// driven and popped when the DUT produces them.
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [9:0] rx_q[$];
    logic       miso_q[$];

    spi_slave_if #(.ADDR_SIZE(8)) bus ();

    spi_slave #(.ADDR_SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives nbits of frame f (MSB first) after the select edge. A full frame is pushed to the
    // scoreboard and popped on the cycle after the last bit; abort_last raises SS_n with bit 0.
    task automatic run_frame(input logic [9:0] f, input int nbits, input bit abort_last);
        logic [9:0] exp;
        bit full;
        full = (nbits == 10) && !abort_last;
        if (full) rx_q.push_back(f);
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = f[9-i];
            if (abort_last && i == nbits - 1) bus.SS_n = 1'b1;
            tick();
            checks++;
            if (full && i == nbits - 1) begin
                if (bus.rx_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_valid_pulse frame %h: got %b expected 1", f, bus.rx_valid);
                end else if (rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got %h expected no frame", bus.rx_data);
                end else begin
                    exp = rx_q.pop_front();
                    if (bus.rx_data !== exp) begin
                        errors++;
                        $display("FAIL rx_data: got %h expected %h", bus.rx_data, exp);
                    end
                end
            end else if (bus.rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL rx_valid_early frame %h bit %0d: got %b expected 0", f, i, bus.rx_valid);
            end
        end
        if (!full) bus.SS_n = 1'b1;
        $display("frame %h bits %0d abort_last %0d done", f, nbits, abort_last);
    endtask

    // Deselects for one cycle; rx_valid must be gone and MISO idle.
    task automatic end_frame();
        bus.SS_n = 1'b1;
        tick();
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.MISO !== 1'b0) begin
            errors++;
            $display("FAIL end_frame: got rx_valid %b MISO %b expected 0 0", bus.rx_valid, bus.MISO);
        end
    endtask

    // tx_valid offered while the engine is not in read-data output: MISO must stay 0.
    task automatic probe_no_miso(input string tag);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d: got MISO %b rx_valid %b expected 0 0", tag, k, bus.MISO, bus.rx_valid);
            end
        end
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
    endtask

    // Presents d one cycle after rx_valid and checks the MISO bit stream. stop_after < 8 aborts
    // with SS_n high after that many bits.
    task automatic send_miso(input logic [7:0] d, input int stop_after);
        logic exp;
        int nb;
        nb = (stop_after < 8) ? stop_after : 8;
        tick();
        for (int b = 0; b < nb; b++) miso_q.push_back(d[7-b]);
        if (stop_after >= 8) miso_q.push_back(1'b0);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~d;
        while (miso_q.size() > 0) begin
            exp = miso_q.pop_front();
            checks++;
            if (bus.MISO !== exp) begin
                errors++;
                $display("FAIL miso_bit data %h remaining %0d: got %b expected %b", d, miso_q.size(), bus.MISO, exp);
            end
            if (miso_q.size() > 0) tick();
        end
        if (stop_after < 8) begin
            bus.SS_n = 1'b1;
            tick();
            checks++;
            if (bus.MISO !== 1'b0) begin
                errors++;
                $display("FAIL miso_abort: got %b expected 0", bus.MISO);
            end
        end else begin
            tick();
            checks++;
            if (bus.MISO !== 1'b0) begin
                errors++;
                $display("FAIL miso_hold_zero: got %b expected 0", bus.MISO);
            end
        end
        $display("miso data %h stop_after %0d done", d, stop_after);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.MISO !== 1'b0 || bus.rx_data !== 10'h000 || bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got MISO %b rx_data %h rx_valid %b expected 0 000 0",
                     bus.MISO, bus.rx_data, bus.rx_valid);
        end
        rst = 1'b0;
        tick();
        $display("reset check done");
    endtask

    task automatic test_write_addr();
        run_frame(10'b00_1010_0101, 10, 1'b0);
        checks++;
        if (bus.MISO !== 1'b0) begin
            errors++;
            $display("FAIL write_addr_miso: got %b expected 0", bus.MISO);
        end
        end_frame();
    endtask

    task automatic test_write_data();
        run_frame(10'h1FF, 10, 1'b0);
        end_frame();
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] f;
        f = 10'h0F0;
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.MOSI = f[9-i];
            tick();
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.MISO !== 1'b0 || bus.rx_data !== 10'h000 || bus.rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_frame cycle %0d: got MISO %b rx_data %h rx_valid %b expected 0 000 0",
                         k, bus.MISO, bus.rx_data, bus.rx_valid);
            end
        end
        bus.SS_n = 1'b1;
        rst = 1'b0;
        tick();
        run_frame(10'h155, 10, 1'b0);
        end_frame();
    endtask

    task automatic test_read_addr_data();
        run_frame(10'h23C, 10, 1'b0);
        probe_no_miso("read_addr_ignores_tx");
        end_frame();
        run_frame(10'h300, 10, 1'b0);
        send_miso(8'hC3, 8);
        end_frame();
        // Flag cleared by the completed read: a MOSI=1 frame is a read address again.
        run_frame(10'h2C1, 10, 1'b0);
        probe_no_miso("flag_cleared_read_addr");
        end_frame();
    endtask

    task automatic test_abort();
        run_frame(10'h3FF, 5, 1'b0);
        end_frame();
        run_frame(10'h3FF, 10, 1'b1);
        end_frame();
        run_frame(10'h3FF, 10, 1'b0);
        send_miso(8'hA5, 3);
        end_frame();
        run_frame(10'h3A5, 10, 1'b0);
        send_miso(8'h5A, 8);
        end_frame();
    endtask

    task automatic test_read_data_no_addr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_frame(10'h3AA, 10, 1'b0);
        probe_no_miso("read_data_without_addr");
        end_frame();
        run_frame(10'h300, 10, 1'b0);
        send_miso(8'h96, 8);
        end_frame();
    endtask

    task automatic test_back_to_back();
        run_frame(10'h055, 10, 1'b0);
        end_frame();
        run_frame(10'h0AA, 10, 1'b0);
        end_frame();
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_reset_mid_frame();
        test_read_addr_data();
        test_abort();
        test_read_data_no_addr();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI slave: deserialises MOSI frames into parallel command/data words for the RAM and serialises RAM read data back onto MISO. It sits directly upstream of the RAM. rx_data/rx_valid drive the RAM's din/rx_valid, and the RAM's dout/tx_valid return as tx_data/tx_valid. The SPI clock is the system clock.

## Interface
- ADDR_SIZE, 8, RAM address/data width; a frame is ADDR_SIZE+2 bits.
- clk  input  1  clock; all sampling and updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- SS_n  input  1  slave select, active low; frames are bounded by SS_n low.
- MOSI  input  1  serial data from master, MSB first.
- MISO  output  1  serial read data to master, MSB first.
- rx_data  output  ADDR_SIZE+2  received frame; bits [ADDR_SIZE+1:ADDR_SIZE] are the command.
- rx_valid  output  1  one-cycle pulse: rx_data holds a complete frame.
- tx_data  input  ADDR_SIZE  read data from RAM.
- tx_valid  input  1  tx_data is valid (from RAM).

## Operation
- Command encoding in rx_data[ADDR_SIZE+1:ADDR_SIZE]:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- States:
  - IDLE: go to CHK_CMD when SS_n=0.
  - CHK_CMD: samples frame bit N-1 (N=ADDR_SIZE+2) into the shift register.
    - MOSI=0 -> WRITE.
    - MOSI=1 and rd_addr_flag=0 -> READ_ADD.
    - MOSI=1 and rd_addr_flag=1 -> READ_DATA.
  - WRITE / READ_ADD: shift in the remaining N-1 bits. On the edge sampling bit 0:
    - rx_data <= {shift, MOSI}; rx_valid <= 1.
    - READ_ADD additionally sets rd_addr_flag.
    - Then remain in state (idle, no further shifting) until SS_n=1.
  - READ_DATA, phase 1: shift in N-1 remaining bits and pulse rx_valid as above. The low ADDR_SIZE bits are dummy and are forwarded as received.
  - READ_DATA, phase 2: wait for tx_valid=1 and latch tx_data. MISO then drives tx_data[ADDR_SIZE-1] .. tx_data[0], one bit per cycle.
  - READ_DATA, after the last bit: MISO <= 0; clear rd_addr_flag; hold until SS_n=1.
- Any state with SS_n=1 -> IDLE on the next edge:
  - partial frame discarded, no rx_valid, bit counter cleared, MISO <= 0;
  - rd_addr_flag retained unless cleared by a completed read-data transfer.
- Command bits are not checked against state; rx_data forwards exactly what was shifted in.
- tx_valid is ignored outside READ_DATA phase 2.
- Bit counter: 4 bits for default ADDR_SIZE; width $clog2(ADDR_SIZE+2) generally; counts down and is reloaded on entry to CHK_CMD.

## Timing
- Reset values: MISO=0, rx_data=0, rx_valid=0, state=IDLE, rd_addr_flag=0, counters 0. Reset mid-frame aborts everything; the first edge after deassertion is treated as IDLE.
- Frame timing, with E0 = the edge where IDLE sees SS_n=0:
  - E1 samples bit N-1.
  - E2..EN sample bits N-2..0.
  - rx_valid is high for exactly the one cycle following EN.
- rx_valid never high for two consecutive cycles. At most one pulse per SS_n-low period.
- Read data: on the edge where tx_valid=1 is sampled, MISO <= tx_data[ADDR_SIZE-1]. Each following edge presents the next bit. MISO returns to 0 on the edge after bit 0 has been held one cycle.
- Simultaneous SS_n=1 and final bit: SS_n wins. No rx_valid, rd_addr_flag unchanged.
- SS_n=1 during MISO output: output aborted, MISO <= 0, rd_addr_flag unchanged.
- No handshake back-pressure: the RAM must accept rx_valid unconditionally.

## Test plan
- Reset mid-frame:
  - Stimulus: assert rst after 4 bits of a write frame, release, then send a full frame 10'h155.
  - Required: all outputs 0 during reset; only 10'h155 is emitted, rx_valid high one cycle after E10.
- Write address:
  - Stimulus: SS_n low, shift 10'b00_1010_0101.
  - Required: rx_data=10'h0A5 and rx_valid=1 for exactly the cycle after E10; MISO stays 0; SS_n high returns to IDLE.
- Write data:
  - Stimulus: shift 10'h1FF.
  - Required: rx_data=10'h1FF, single rx_valid pulse; rd_addr_flag stays 0.
- Read address then read data:
  - Stimulus: send 10'h23C (READ_ADD, flag set). New frame 10'h300; tx_valid=1 with tx_data=8'hC3 two cycles after rx_valid.
  - Required: rx_data=10'h23C, then 10'h300; MISO=1,1,0,0,0,0,1,1 on consecutive cycles, then 0; flag cleared, so the next MOSI=1 frame enters READ_ADD.
- Abort:
  - Stimulus: SS_n high after 5 bits of a frame; also SS_n high on the same edge as bit 0.
  - Required: no rx_valid in either case; state IDLE next cycle; next full frame decoded correctly.
- Read data without read address:
  - Stimulus: from reset, send 10'h3AA.
  - Required: enters READ_ADD (flag=0), rx_valid with 10'h3AA, flag set, MISO remains 0 with no wait on tx_valid.
